// File: rtl/aqp_ebus_pkg.sv
// Shared definitions for the aqp_ebus_master external-bus cycle master:
// bus-cycle phase encoding, idle strobe value and strobe decode helper.
package aqp_ebus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1A  = 4'd1,
    ST_T1B  = 4'd2,
    ST_T2A  = 4'd3,
    ST_T2B  = 4'd4,
    ST_TWA  = 4'd5,
    ST_TWB  = 4'd6,
    ST_T3A  = 4'd7,
    ST_T3B  = 4'd8
  } ebus_state_e;

  // Strobe vector order is {rd_n, wr_n, mreq_n, iorq_n}.
  localparam logic [3:0] STROBE_IDLE = 4'b1111;
  localparam int         IO_WAIT_MAX = 3;

  // Active-low strobes for the phase being entered; memory cycles open mreq
  // (and rd for reads) one half-period earlier than IO cycles.
  function automatic logic [3:0] strobe_decode(input ebus_state_e st,
                                               input logic wr,
                                               input logic io);
    logic mid_s;
    logic t1b_s;
    mid_s = (st == ST_T2A) || (st == ST_T2B) || (st == ST_TWA) ||
            (st == ST_TWB) || (st == ST_T3A);
    t1b_s = (st == ST_T1B);
    return {~(~wr & ((~io & t1b_s) | mid_s)),
            ~(wr & mid_s),
            ~(~io & (t1b_s | mid_s)),
            ~(io & mid_s)};
  endfunction

endpackage

// File: rtl/aqp_ebus_master.sv
// Z80-style expansion-bus cycle master; phases advance only on ebus_phi_clken.
// Define AQP_EBUS_WAIT_EN to honour ebus_wait_n (otherwise only forced IO waits).
module aqp_ebus_master
  import aqp_ebus_pkg::*;
#(
  parameter int IO_WAIT_STATES = 1,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  ebus_phi_clken,
  input  logic                  req,
  input  logic                  req_wr,
  input  logic                  req_io,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_wrdata,
  output logic                  busy,
  output logic                  ack,
  output logic [7:0]            rddata,
  output logic [ADDR_WIDTH-1:0] ebus_a,
  output logic [7:0]            ebus_d_out,
  output logic                  ebus_d_oe,
  input  logic [7:0]            ebus_d_in,
  output logic                  ebus_rd_n,
  output logic                  ebus_wr_n,
  output logic                  ebus_mreq_n,
  output logic                  ebus_iorq_n,
  input  logic                  ebus_wait_n
);

  localparam logic [1:0] IO_WAIT_CNT = (IO_WAIT_STATES > IO_WAIT_MAX) ?
                                       2'(IO_WAIT_MAX) : 2'(IO_WAIT_STATES);

  ebus_state_e           state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  wr_q, wr_d;
  logic                  io_q, io_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            rddata_q, rddata_d;
  logic [ADDR_WIDTH-1:0] ebus_a_q, ebus_a_d;
  logic [7:0]            d_out_q, d_out_d;
  logic                  d_oe_q, d_oe_d;
  logic [3:0]            strobe_q, strobe_d;
  logic [1:0]            fwait_q, fwait_d;
  logic                  wait_low_s;

`ifdef AQP_EBUS_WAIT_EN
  logic [1:0] wait_sync_q;

  // Two-flop synchronizer for the asynchronous bus wait input.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wait_sync_q <= 2'b11;
    end else begin
      wait_sync_q <= {wait_sync_q[0], ebus_wait_n};
    end
  end

  assign wait_low_s = ~wait_sync_q[1];
`else
  logic unused_wait_s;
  assign unused_wait_s = ebus_wait_n;
  assign wait_low_s    = 1'b0;
`endif

  // Next-state, request latching and bus output computation.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    wr_d     = wr_q;
    io_d     = io_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rddata_d = rddata_q;
    ebus_a_d = ebus_a_q;
    d_out_d  = d_out_q;
    d_oe_d   = d_oe_q;
    fwait_d  = fwait_q;
    case (state_q)
      ST_IDLE: begin
        // busy with IDLE means accepted and waiting for the first clken.
        if (!busy_q) begin
          if (req) begin
            busy_d  = 1'b1;
            wr_d    = req_wr;
            io_d    = req_io;
            addr_d  = req_addr;
            wdata_d = req_wrdata;
          end else begin
            busy_d = 1'b0;
          end
        end else if (ebus_phi_clken) begin
          state_d  = ST_T1A;
          ebus_a_d = addr_q;
          if (wr_q) begin
            d_out_d = wdata_q;
            d_oe_d  = 1'b1;
          end else begin
            d_oe_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1A:  if (ebus_phi_clken) state_d = ST_T1B; else state_d = ST_T1A;
      ST_T1B:  if (ebus_phi_clken) state_d = ST_T2A; else state_d = ST_T1B;
      ST_T2A:  if (ebus_phi_clken) state_d = ST_T2B; else state_d = ST_T2A;
      ST_T2B: begin
        if (ebus_phi_clken) begin
          if (io_q && (IO_WAIT_CNT != 2'd0)) begin
            state_d = ST_TWA;
            fwait_d = IO_WAIT_CNT - 2'd1;
          end else if (wait_low_s) begin
            state_d = ST_TWA;
          end else begin
            state_d = ST_T3A;
          end
        end else begin
          state_d = ST_T2B;
        end
      end
      ST_TWA:  if (ebus_phi_clken) state_d = ST_TWB; else state_d = ST_TWA;
      ST_TWB: begin
        if (ebus_phi_clken) begin
          if (fwait_q != 2'd0) begin
            state_d = ST_TWA;
            fwait_d = fwait_q - 2'd1;
          end else if (wait_low_s) begin
            state_d = ST_TWA;
          end else begin
            state_d = ST_T3A;
          end
        end else begin
          state_d = ST_TWB;
        end
      end
      ST_T3A: begin
        if (ebus_phi_clken) begin
          state_d = ST_T3B;
          if (!wr_q) begin
            rddata_d = ebus_d_in;
          end else begin
            rddata_d = rddata_q;
          end
        end else begin
          state_d = ST_T3A;
        end
      end
      ST_T3B: begin
        if (ebus_phi_clken) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          d_oe_d  = 1'b0;
        end else begin
          state_d = ST_T3B;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        d_oe_d  = 1'b0;
      end
    endcase
    strobe_d = strobe_decode(state_d, wr_q, io_q);
  end

  // State and registered bus outputs; async reset drops any cycle in flight.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rddata_q <= 8'h00;
      ebus_a_q <= '0;
      d_out_q  <= 8'h00;
      d_oe_q   <= 1'b0;
      strobe_q <= STROBE_IDLE;
      fwait_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      wr_q     <= wr_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rddata_q <= rddata_d;
      ebus_a_q <= ebus_a_d;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      strobe_q <= strobe_d;
      fwait_q  <= fwait_d;
    end
  end

  assign busy        = busy_q;
  assign ack         = ack_q;
  assign rddata      = rddata_q;
  assign ebus_a      = ebus_a_q;
  assign ebus_d_out  = d_out_q;
  assign ebus_d_oe   = d_oe_q;
  assign ebus_rd_n   = strobe_q[3];
  assign ebus_wr_n   = strobe_q[2];
  assign ebus_mreq_n = strobe_q[1];
  assign ebus_iorq_n = strobe_q[0];

endmodule

// File: tb/tb_aqp_ebus_master.sv
// Self-checking bench for aqp_ebus_master: directed and randomized transfers
// checked phase-by-phase against a clken-count timeline model.
module tb_aqp_ebus_master;

`ifdef AQP_EBUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int IOW = 1;

  logic        sysclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_io = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wrdata = 8'h00;
  logic [7:0]  ebus_d_in = 8'h00;
  logic        ebus_wait_n = 1'b1;
  logic        busy, ack, ebus_d_oe;
  logic        ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n;
  logic [7:0]  rddata, ebus_d_out;
  logic [15:0] ebus_a;

  int          nvec = 0;
  int          nmis = 0;
  int          ph = 0;
  logic [7:0]  exp_rd = 8'h00;
  logic        wl[64];
  logic [7:0]  dv[64];

  aqp_ebus_master #(.IO_WAIT_STATES(IOW), .ADDR_WIDTH(16)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .ebus_phi_clken(clken),
    .req(req), .req_wr(req_wr), .req_io(req_io), .req_addr(req_addr),
    .req_wrdata(req_wrdata), .busy(busy), .ack(ack), .rddata(rddata),
    .ebus_a(ebus_a), .ebus_d_out(ebus_d_out), .ebus_d_oe(ebus_d_oe),
    .ebus_d_in(ebus_d_in), .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n),
    .ebus_mreq_n(ebus_mreq_n), .ebus_iorq_n(ebus_iorq_n),
    .ebus_wait_n(ebus_wait_n)
  );

  always #5 sysclk = ~sysclk;

  // phi half-period enable: one pulse every 4 sysclk
  always @(negedge sysclk) begin
    ph = (ph + 1) % 4;
    clken = (ph == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected {d_oe, rd_n, wr_n, mreq_n, iorq_n} during clken interval p
  // (p = clkens seen since accept; interval 1 is T1A, nw = TW pairs).
  function automatic logic [4:0] exp_bus(input int p, input bit wr, input bit io, input int nw);
    int t3a;
    logic doe, rd_lo, wr_lo, mreq_lo, io_lo;
    t3a     = 5 + 2 * nw;
    doe     = wr && (p >= 1) && (p <= t3a + 1);
    mreq_lo = !io && (p >= 2) && (p <= t3a);
    rd_lo   = !wr && (p >= (io ? 3 : 2)) && (p <= t3a);
    wr_lo   = wr && (p >= 3) && (p <= t3a);
    io_lo   = io && (p >= 3) && (p <= t3a);
    return {doe, ~rd_lo, ~wr_lo, ~mreq_lo, ~io_lo};
  endfunction

  // wmode: 0 random wait, 1 wait held low, 2 wait high; dfix[8] fixes read data;
  // rst_at > 0 pulses reset_n in that clken interval and drops the transfer.
  task automatic run_xfer(input bit wr, input bit io, input logic [15:0] addr,
                          input logic [7:0] wd, input int wmode,
                          input logic [8:0] dfix, input int rst_at);
    int  nw, p;
    bit  done, fresh;
    logic [4:0] eb;
    for (int i = 0; i < 64; i++) begin
      if (i >= 41) wl[i] = 1'b1;
      else if (wmode == 1) wl[i] = 1'b0;
      else if (wmode == 2) wl[i] = 1'b1;
      else wl[i] = ($urandom_range(0, 2) != 0);
      dv[i] = dfix[8] ? dfix[7:0] : 8'($urandom);
    end
    nw = io ? IOW : 0;
    while (WAIT_EN && (nw < 25) && !wl[5 + 2 * nw]) nw++;
    if (!wr) exp_rd = dv[5 + 2 * nw];

    repeat ($urandom_range(0, 5)) @(negedge sysclk);
    req = 1'b1; req_wr = wr; req_io = io; req_addr = addr; req_wrdata = wd;
    ebus_d_in = dv[0]; ebus_wait_n = wl[1];
    @(posedge sysclk);
    @(negedge sysclk);
    req = 1'b0; req_addr = ~addr; req_wrdata = ~wd;
    chk("busy_after_accept", busy, 1'b1);
    p = 0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge sysclk);
      fresh = clken;
      if (fresh) p++;
      @(negedge sysclk);
      if (fresh) begin
        ebus_wait_n = wl[(p + 1) % 64];
        ebus_d_in   = dv[p % 64];
      end
      eb = (p >= 7 + 2 * nw) ? 5'b01111 : exp_bus(p, wr, io, nw);
      chk("strobes", {ebus_d_oe, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n}, eb);
      if (p >= 1) chk("ebus_a", ebus_a, addr);
      if (p >= 1 && wr) chk("d_out", ebus_d_out, wd);
      if (fresh && p == 7 + 2 * nw) begin
        chk("ack", ack, 1'b1);
        chk("busy_at_ack", busy, 1'b0);
        chk("rddata", rddata, exp_rd);
        done = 1'b1;
      end else begin
        chk("no_ack", ack, 1'b0);
      end
      if (rst_at > 0 && fresh && p == rst_at) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_strobes", {ebus_d_oe, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n}, 5'b01111);
        chk("rst_busy", busy, 1'b0);
        #2 reset_n = 1'b1;
        exp_rd = 8'h00;
        for (int k = 0; k < 40; k++) begin
          @(negedge sysclk);
          chk("rst_no_ack", {ack, busy, ebus_d_oe, ebus_mreq_n, ebus_iorq_n}, 5'b00011);
        end
        return;
      end
    end
    chk("ack_timeout", done, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    chk("reset_out", {busy, ack, ebus_d_oe, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n},
        7'b0001111);
    chk("reset_data", {rddata, ebus_d_out, ebus_a}, 32'h0);
    reset_n = 1'b1;
    @(negedge sysclk);
    chk("idle_busy", busy, 1'b0);

    run_xfer(1'b0, 1'b0, 16'h3000, 8'h00, 2, 9'h1A5, 0);
    run_xfer(1'b1, 1'b0, 16'h4001, 8'h5A, 2, 9'h000, 0);
    run_xfer(1'b0, 1'b1, 16'h00F6, 8'h00, 2, 9'h000, 0);
    run_xfer(1'b0, 1'b0, 16'h1234, 8'h00, 0, 9'h000, 0);
    run_xfer(1'b0, 1'b0, 16'h3000, 8'h00, 1, 9'h1C3, 0);
    run_xfer(1'b1, 1'b0, 16'h5555, 8'hE7, 2, 9'h000, 3);
    run_xfer(1'b0, 1'b0, 16'h2222, 8'h00, 2, 9'h000, 0);
    run_xfer(1'b1, 1'b1, 16'h00F7, 8'h3C, 2, 9'h000, 0);
    for (int t = 0; t < 30; t++) begin
      run_xfer(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 0, 9'h000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
